// File: rtl/gv_chart_pkg.sv
// Shared types and default sizing for the chart sequencer and its consumers.
// HIT_IDX is the window bit the hit scorer treats as the hit line.
package gv_chart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PLAY,
        PAUSE,
        DRAIN,
        DONE
    } seq_state_t;

    localparam int WIN_W   = 40;
    localparam int CNT_W   = 23;
    localparam int ADDR_W  = 8;
    localparam int MIN_LIM = 4;
    localparam int HIT_IDX = 37;

endpackage

// File: rtl/beat_timer.sv
// Beat phase counter: counts 0..lim-1 while enabled and flags the wrap cycle,
// which is the cycle on which the note window shifts.
module beat_timer #(
    parameter int CNT_W = gv_chart_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] lim,
    output logic [CNT_W-1:0] counter,
    output logic             wrap
);

    logic [CNT_W-1:0] counter_q;

    assign wrap    = en && (counter_q == lim - CNT_W'(1));
    assign counter = counter_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            counter_q <= '0;
        end else if (clr || wrap) begin
            counter_q <= '0;
        end else if (en) begin
            counter_q <= counter_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/note_chart_sequencer.sv
// Song-chart sequencer: prefetches one note per beat from a synchronous ROM,
// shifts it into the note window, then drains WIN_W zeros before reporting done.
module note_chart_sequencer #(
    parameter int WIN_W   = gv_chart_pkg::WIN_W,
    parameter int CNT_W   = gv_chart_pkg::CNT_W,
    parameter int ADDR_W  = gv_chart_pkg::ADDR_W,
    parameter int MIN_LIM = gv_chart_pkg::MIN_LIM
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic              pause,
    input  logic [CNT_W-1:0]  tempo_lim,
    input  logic [ADDR_W-1:0] song_len,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic              rom_data,
    output logic [WIN_W-1:0]  padded_notes,
    output logic [CNT_W-1:0]  counter,
    output logic [CNT_W-1:0]  lim,
    output logic              beat,
    output logic              playing,
    output logic              done
);
    import gv_chart_pkg::*;

    localparam int DRAIN_W = $clog2(WIN_W + 1);

    seq_state_t         state_q;
    seq_state_t         resume_q;
    logic [CNT_W-1:0]   lim_q;
    logic [ADDR_W-1:0]  len_q;
    logic [ADDR_W-1:0]  note_idx_q;
    logic               note_buf_q;
    logic [DRAIN_W-1:0] drain_cnt_q;
    logic [WIN_W-1:0]   window_q;
    logic               playing_q;
    logic               done_q;

    logic               accept;
    logic               timer_en;
    logic               wrap;
    logic [CNT_W-1:0]   count;

    assign accept   = start && (state_q == IDLE || state_q == DONE);
    assign timer_en = (state_q == PLAY || state_q == DRAIN) && !pause;

    beat_timer #(
        .CNT_W(CNT_W)
    ) u_beat_timer (
        .clk    (clk),
        .n_rst  (n_rst),
        .clr    (accept),
        .en     (timer_en),
        .lim    (lim_q),
        .counter(count),
        .wrap   (wrap)
    );

    // NOTE: all state here uses <= so every branch reads the pre-edge values,
    // e.g. the shift uses the old note_buf even when it is reloaded the same edge.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            resume_q    <= PLAY;
            lim_q       <= '0;
            len_q       <= '0;
            note_idx_q  <= '0;
            note_buf_q  <= 1'b0;
            drain_cnt_q <= '0;
            window_q    <= '0;
            playing_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        lim_q       <= (tempo_lim < CNT_W'(MIN_LIM)) ? CNT_W'(MIN_LIM) : tempo_lim;
                        len_q       <= song_len;
                        note_idx_q  <= '0;
                        note_buf_q  <= 1'b0;
                        drain_cnt_q <= '0;
                        window_q    <= '0;
                        playing_q   <= 1'b1;
                        done_q      <= 1'b0;
                        state_q     <= (song_len == '0) ? DRAIN : PLAY;
                    end
                end
                PLAY: begin
                    if (pause) begin
                        state_q  <= PAUSE;
                        resume_q <= PLAY;
                    end else begin
                        // ROM answered the address set on the last shift; capture before the next one.
                        if (count == CNT_W'(1)) begin
                            note_buf_q <= rom_data;
                        end
                        if (wrap) begin
                            window_q   <= {window_q[WIN_W-2:0], note_buf_q};
                            note_idx_q <= note_idx_q + ADDR_W'(1);
                            if (note_idx_q == len_q - ADDR_W'(1)) begin
                                state_q <= DRAIN;
                            end
                        end
                    end
                end
                PAUSE: begin
                    if (!pause) begin
                        state_q <= resume_q;
                    end
                end
                DRAIN: begin
                    if (pause) begin
                        state_q  <= PAUSE;
                        resume_q <= DRAIN;
                    end else if (wrap) begin
                        window_q    <= {window_q[WIN_W-2:0], 1'b0};
                        drain_cnt_q <= drain_cnt_q + DRAIN_W'(1);
                        if (drain_cnt_q == DRAIN_W'(WIN_W - 1)) begin
                            state_q   <= DONE;
                            window_q  <= '0;
                            playing_q <= 1'b0;
                            done_q    <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rom_addr     = note_idx_q;
    assign padded_notes = window_q;
    assign counter      = count;
    assign lim          = lim_q;
    assign beat         = wrap;
    assign playing      = playing_q;
    assign done         = done_q;

endmodule

// File: tb/tb_note_chart_sequencer.sv
// Self-checking bench for note_chart_sequencer: directed sequences, a table of
// tempo/length cases, and randomized songs checked against a beat-count model.
module tb_note_chart_sequencer;
    import gv_chart_pkg::*;

    logic              clk = 1'b0;
    logic              n_rst;
    logic              start;
    logic              pause;
    logic [CNT_W-1:0]  tempo_lim;
    logic [ADDR_W-1:0] song_len;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_data = 1'b0;
    logic [WIN_W-1:0]  padded_notes;
    logic [CNT_W-1:0]  counter;
    logic [CNT_W-1:0]  lim;
    logic              beat;
    logic              playing;
    logic              done;

    logic rom_mem [0:255];

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: beats completed since start, phase within the beat, etc.
    int m_k, m_len, m_phase, m_lim;
    bit m_active, m_done, m_frozen;

    typedef struct {
        int tempo;
        int len;
        int exp_lim;
        int exp_clocks;
    } song_vec_t;

    song_vec_t vecs [7];

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    note_chart_sequencer dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .start       (start),
        .pause       (pause),
        .tempo_lim   (tempo_lim),
        .song_len    (song_len),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .padded_notes(padded_notes),
        .counter     (counter),
        .lim         (lim),
        .beat        (beat),
        .playing     (playing),
        .done        (done)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic do_start(input int t, input int l);
        tempo_lim = CNT_W'(t);
        song_len  = ADDR_W'(l);
        start     = 1'b1;
        cyc();
        start     = 1'b0;
    endtask

    task automatic wait_counter(input int v, input string name);
        int n;
        n = 0;
        while (counter != CNT_W'(v) && n < 40) begin
            cyc();
            n++;
        end
        check(name, counter, v);
    endtask

    task automatic wait_done(input int bound, input string name);
        int n;
        n = 0;
        while (!done && n < bound) begin
            cyc();
            n++;
        end
        check(name, done, 1);
    endtask

    // Window after k beats: bit i holds chart note k-1-i when that note exists.
    function automatic logic [WIN_W-1:0] exp_window();
        logic [WIN_W-1:0] w;
        w = '0;
        for (int i = 0; i < WIN_W; i++) begin
            int j;
            j = m_k - 1 - i;
            if (j >= 0 && j < m_len) w[i] = rom_mem[j];
        end
        return w;
    endfunction

    // The timer stalls on any cycle pause is high, and on the cycle after.
    task automatic model_step(input bit st, input bit ps, input int tl, input int sl);
        bit run;
        run = m_active && !ps && !m_frozen;
        if (st && !m_active) begin
            m_lim    = (tl < MIN_LIM) ? MIN_LIM : tl;
            m_len    = sl;
            m_k      = 0;
            m_phase  = 0;
            m_active = 1'b1;
            m_done   = 1'b0;
            m_frozen = 1'b0;
        end else if (m_active) begin
            m_frozen = ps;
            if (run) begin
                if (m_phase == m_lim - 1) begin
                    m_phase = 0;
                    m_k++;
                    if (m_k == m_len + WIN_W) begin
                        m_active = 1'b0;
                        m_done   = 1'b1;
                    end
                end else begin
                    m_phase++;
                end
            end
        end
    endtask

    initial begin
        int n, b, bad, pause_left, len_r, tempo_r;
        bit first, exp_beat;
        logic [ADDR_W-1:0] a_addr;
        logic [WIN_W-1:0]  a_win;

        vecs[0] = '{8, 3, 8, 344};
        vecs[1] = '{2, 0, 4, 160};
        vecs[2] = '{0, 0, 4, 160};
        vecs[3] = '{4, 1, 4, 164};
        vecs[4] = '{5, 2, 5, 210};
        vecs[5] = '{3, 5, 4, 180};
        vecs[6] = '{9, 0, 9, 360};

        for (int i = 0; i < 256; i++) rom_mem[i] = 1'b0;
        start = 1'b0; pause = 1'b0; tempo_lim = '0; song_len = '0;
        n_rst = 1'b1;
        #2 n_rst = 1'b0;
        #1 check("reset_outputs", |{rom_addr, padded_notes, counter, lim, beat, playing, done}, 0);
        cyc();
        n_rst = 1'b1;
        cyc();

        // Basic sequence, drain and finish.
        rom_mem[0] = 1'b1; rom_mem[1] = 1'b0; rom_mem[2] = 1'b1;
        do_start(8, 3);
        check("start_lim", lim, 8);
        check("start_playing", {playing, done}, 2'b10);
        check("start_addr", rom_addr, 0);
        n = 0; b = 0;
        while (b < 43 && n < 400) begin
            if (beat) begin
                b++;
                check($sformatf("beat%0d_time", b), n, 8 * b - 1);
                cyc(); n++;
                case (b)
                    1: check("win_b1", padded_notes[2:0], 3'b001);
                    2: check("win_b2", padded_notes[2:0], 3'b010);
                    3: begin
                        check("win_b3", padded_notes[2:0], 3'b101);
                        check("playing_b3", playing, 1);
                    end
                    38: check("hit_b38", padded_notes[HIT_IDX], 1);
                    39: check("hit_b39", padded_notes[HIT_IDX], 0);
                    40: check("hit_b40", padded_notes[HIT_IDX], 1);
                    41: check("hit_b41", padded_notes[HIT_IDX], 0);
                    default: ;
                endcase
            end else begin
                cyc(); n++;
            end
        end
        check("basic_beats", b, 43);
        check("basic_clocks", n, 344);
        check("basic_done", {done, playing}, 2'b10);
        check("basic_window_clear", padded_notes, 0);
        check("basic_counter_idle", counter, 0);

        // Table: clamp, empty songs, and total song duration.
        for (int v = 0; v < 7; v++) begin
            for (int i = 0; i < 8; i++) rom_mem[i] = 1'($urandom_range(0, 1));
            do_start(vecs[v].tempo, vecs[v].len);
            check($sformatf("tbl%0d_lim", v), lim, vecs[v].exp_lim);
            check($sformatf("tbl%0d_playing", v), {playing, done}, 2'b10);
            n = 0;
            while (!done && n < 2000) begin
                cyc(); n++;
            end
            check($sformatf("tbl%0d_clocks", v), n, vecs[v].exp_clocks);
            check($sformatf("tbl%0d_addr_end", v), rom_addr, vecs[v].len);
            check($sformatf("tbl%0d_window_end", v), padded_notes, 0);
        end

        // Pause for 20 clocks at counter 5.
        do_start(8, 5);
        wait_counter(5, "pause_reach_5");
        pause = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (counter != CNT_W'(5) || beat) bad++;
        end
        check("pause_hold", bad, 0);
        pause = 1'b0;
        n = 0;
        while (!beat && n < 20) begin
            cyc(); n++;
        end
        check("pause_resume_latency", n, 3);

        // Start mid-PLAY is ignored.
        wait_counter(2, "ignore_reach_2");
        a_addr = rom_addr;
        a_win  = padded_notes;
        do_start(20, 1);
        check("ignore_lim", lim, 8);
        check("ignore_counter", counter, 3);
        check("ignore_addr", rom_addr, a_addr);
        check("ignore_window", padded_notes, a_win);
        check("ignore_playing", playing, 1);
        wait_done(600, "ignore_song_done");

        // Restart from DONE.
        do_start(12, 3);
        check("restart_counter", counter, 0);
        check("restart_window", padded_notes, 0);
        check("restart_addr", rom_addr, 0);
        check("restart_status", {playing, done}, 2'b10);
        check("restart_lim", lim, 12);

        // Asynchronous reset at beat 10.
        n = 0; b = 0;
        while (b < 10 && n < 200) begin
            if (beat) b++;
            if (b < 10) begin
                cyc(); n++;
            end
        end
        check("rst_reach_b10", b, 10);
        n_rst = 1'b0;
        #1 check("rst_async_outputs", |{rom_addr, padded_notes, counter, lim, beat, playing, done}, 0);
        cyc(); cyc();
        n_rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (beat || playing || counter != '0) bad++;
        end
        check("rst_stays_idle", bad, 0);

        // Randomized songs against the model; DUT is in IDLE after the reset above.
        m_k = 0; m_len = 0; m_phase = 0; m_lim = 0;
        m_active = 1'b0; m_done = 1'b0; m_frozen = 1'b0;
        pause_left = 0;
        for (int s = 0; s < 6 && n_fail < 20; s++) begin
            len_r   = $urandom_range(0, 8);
            tempo_r = $urandom_range(0, 9);
            for (int i = 0; i < len_r; i++) rom_mem[i] = 1'($urandom_range(0, 1));
            first = 1'b1;
            n = 0;
            while (n < 1500 && n_fail < 20) begin
                if (first) begin
                    start = 1'b1; tempo_lim = CNT_W'(tempo_r); song_len = ADDR_W'(len_r);
                end else begin
                    start     = ($urandom_range(0, 40) == 0);
                    tempo_lim = CNT_W'($urandom_range(0, 30));
                    song_len  = ADDR_W'($urandom_range(0, 20));
                end
                if (pause_left > 0) begin
                    pause = 1'b1; pause_left--;
                end else if ($urandom_range(0, 30) == 0) begin
                    pause = 1'b1; pause_left = $urandom_range(0, 5);
                end else begin
                    pause = 1'b0;
                end
                #1;
                exp_beat = m_active && !pause && !m_frozen && (m_phase == m_lim - 1);
                check("rand_window", padded_notes, exp_window());
                check("rand_counter", counter, m_phase);
                check("rand_beat", beat, exp_beat);
                check("rand_status", {playing, done}, {m_active, m_done});
                check("rand_lim", lim, m_lim);
                check("rand_rom_addr", rom_addr, (m_k < m_len) ? m_k : m_len);
                model_step(start, pause, int'(tempo_lim), int'(song_len));
                cyc();
                n++;
                first = 1'b0;
                if (m_done) break;
            end
            start = 1'b0;
            pause = 1'b0;
            pause_left = 0;
            check($sformatf("rand_song%0d_finished", s), done, 1);
            m_frozen = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
        $fatal(1);
    end

endmodule

// File: doc/note_chart_sequencer.md
Name: note_chart_sequencer

Overview:
- Producer side of the note-window interface that the hit scorer consumes.
- Reads a song chart from an external synchronous note ROM, one note bit per beat.
- Runs the beat timer and shifts the note window by one position per beat, producing padded_notes, counter, lim and a beat pulse.
- After the last chart note, shifts in WIN_W zero bits so every note passes the hit line, then reports done.

Parameters:
- WIN_W, 40, width of padded_notes window.
- CNT_W, 23, width of counter/lim/tempo_lim.
- ADDR_W, 8, chart ROM address width; max song length 2^ADDR_W-1 notes.
- MIN_LIM, 4, minimum accepted beat period in clocks.

Ports:
- clk  in  1  system clock.
- n_rst  in  1  asynchronous, active-low reset.
- start  in  1  pulse; begin song (honoured only in IDLE or DONE).
- pause  in  1  level; freezes timer and window while high.
- tempo_lim  in  CNT_W  beat period in clocks, sampled on accepted start.
- song_len  in  ADDR_W  number of chart notes, sampled on accepted start.
- rom_addr  out  ADDR_W  chart ROM address.
- rom_data  in  1  chart note bit; valid one clock after rom_addr changes.
- padded_notes  out  WIN_W  note window; new notes enter at bit 0.
- counter  out  CNT_W  beat phase, 0..lim-1.
- lim  out  CNT_W  latched beat period.
- beat  out  1  one-cycle pulse on the cycle the window shifts.
- playing  out  1  high in PLAY, PAUSE, DRAIN.
- done  out  1  high in DONE until next accepted start.

Behaviour:
- Reset values: all outputs 0; state IDLE; note_idx 0; note_buf 0; drain_cnt 0.
- States:
  - IDLE -> PLAY on start.
  - PLAY -> PAUSE while pause; PLAY -> DRAIN on the shift that consumes note song_len-1.
  - PAUSE -> resume state (PLAY or DRAIN) when pause low.
  - DRAIN -> DONE on the WIN_W-th drain shift.
  - DONE -> PLAY on start.
- Accepted start (registered, one edge):
  - lim <= max(tempo_lim, MIN_LIM); len <= song_len.
  - counter <= 0; padded_notes <= 0; note_idx <= 0; drain_cnt <= 0; done <= 0.
  - If song_len == 0, go directly to DRAIN.
- start outside IDLE/DONE is ignored. start and pause high together in IDLE: start wins, enter PLAY; PAUSE is entered the next cycle.
- Timer (PLAY/DRAIN, not paused):
  - counter increments; at counter == lim-1, counter <= 0 and beat = 1 on that cycle.
  - Shift occurs on the same edge: padded_notes <= {padded_notes[WIN_W-2:0], in_bit}.
- in_bit:
  - PLAY: note_buf, then note_idx increments.
  - DRAIN: 0, then drain_cnt increments.
- Prefetch:
  - rom_addr = note_idx (registered).
  - note_buf <= rom_data when counter == 1 in PLAY.
  - MIN_LIM >= 4 guarantees ROM latency is met before the shift.
- PAUSE: counter, padded_notes, note_idx and drain_cnt hold; beat = 0; lim unchanged.
- DONE: counter holds 0; padded_notes all zero; beat 0.
- Mid-operation reset returns everything to the reset values immediately (asynchronous).
- No wrap-around of note_idx: maximum is len, and at len the state leaves PLAY.

Decomposition:
- Package gv_chart_pkg:
  - seq_state_t enum {IDLE, PLAY, PAUSE, DRAIN, DONE}.
  - WIN_W, CNT_W, ADDR_W, MIN_LIM defaults.
  - HIT_IDX = 37, the window bit the scorer treats as the hit line.
- Sub-module beat_timer:
  - Inputs: clk, n_rst, clr, en, lim.
  - Outputs: counter, wrap.
  - Instantiated once; the FSM drives en = (PLAY|DRAIN) & ~pause.

Test Plan:
- Basic sequence:
  - Stimulus: tempo_lim=8, song_len=3, ROM={1,0,1}, start.
  - Response: beat every 8 clocks. padded_notes[2:0] = 001 after beat 1, 010 after beat 2, 101 after beat 3. playing=1.
- Drain and finish:
  - Stimulus: same as basic sequence.
  - Response: after 43 beats (344 clocks after start), done=1, playing=0, padded_notes=0. Window bit 37 is 1 on beats 38 and 40.
- Pause:
  - Stimulus: assert pause for 20 clocks at counter=5.
  - Response: counter stays 5, no beat. Next beat arrives exactly 3 clocks after pause drops.
- Clamp and empty song:
  - Stimulus: tempo_lim=2 -> lim=4. song_len=0.
  - Response: enters DRAIN immediately; done after 40 beats (160 clocks).
- Ignored start and restart:
  - Stimulus: start pulse mid-PLAY; later start in DONE.
  - Response: mid-PLAY start causes no change. Start in DONE restarts with counter=0, window=0, rom_addr=0.
- Reset mid-song:
  - Stimulus: n_rst low at beat 10.
  - Response: all outputs 0 asynchronously; no beat until a new start.
